// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl: sequences a two-phase (phi/phi_bar) scan chain with capture/update strobes.
// Optional sticky phase-overlap detector: define SCAN_CHAIN_CTRL_OVERLAP_CHK_EN.
module scan_chain_ctrl #(
  parameter int DATA_W = 32,
  parameter int PHI_W  = 2,
  parameter int GAP_W  = 1,
  parameter int UPD_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [1:0]                  cmd_op,
  input  logic [$clog2(DATA_W+1)-1:0] cmd_len,
  input  logic [DATA_W-1:0]           cmd_data,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic                        chain_si,
  input  logic                        chain_so,
  output logic                        phi,
  output logic                        phi_bar,
  output logic                        capture,
  output logic                        update,
  output logic                        err_overlap
);

  localparam int LEN_W   = $clog2(DATA_W+1);
  localparam int CNT_MAX = (PHI_W > GAP_W) ? ((PHI_W > UPD_W) ? PHI_W : UPD_W)
                                           : ((GAP_W > UPD_W) ? GAP_W : UPD_W);
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [1:0]       OP_SHIFT   = 2'b00;
  localparam logic [1:0]       OP_CAPTURE = 2'b01;
  localparam logic [1:0]       OP_UPDATE  = 2'b10;
  localparam logic [CNT_W-1:0] PHI_LD     = CNT_W'(PHI_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(GAP_W - 1);
  localparam logic [CNT_W-1:0] UPD_LD     = CNT_W'(UPD_W - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(DATA_W);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_SETUP    = 4'd1,
    S_PHI      = 4'd2,
    S_GAP1     = 4'd3,
    S_PHIB     = 4'd4,
    S_GAP2     = 4'd5,
    S_CAP_SET  = 4'd6,
    S_CAP_PHIB = 4'd7,
    S_CAP_HOLD = 4'd8,
    S_UPD      = 4'd9,
    S_DONE     = 4'd10
  } state_t;

  state_t            state_r, state_s;
  logic [CNT_W-1:0]  cnt_r, cnt_s;
  logic [LEN_W-1:0]  bit_r, bit_s;
  logic [LEN_W-1:0]  len_r, len_clamp_s;
  logic [1:0]        op_r;
  logic [DATA_W-1:0] data_r, data_src_s, data_shift_s;
  logic [DATA_W-1:0] shift_in_r;
  logic              accept_s, in_shift_s;

  logic              phi_r, phi_bar_r, capture_r, update_r, chain_si_r;
  logic              rsp_valid_r, cmd_ready_r, busy_r;
  logic [DATA_W-1:0] rsp_data_r;

  // Next-state, phase counter and bit index selection.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_s       = bit_r;
    accept_s    = 1'b0;
    len_clamp_s = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          bit_s    = LEN_ZERO;
          case (cmd_op)
            OP_SHIFT: begin
              if (len_clamp_s != LEN_ZERO) begin
                state_s = S_SETUP;
              end else begin
                state_s = S_DONE;
              end
            end
            OP_CAPTURE: state_s = S_CAP_SET;
            OP_UPDATE: begin
              state_s = S_UPD;
              cnt_s   = UPD_LD;
            end
            default: state_s = S_DONE;
          endcase
        end else begin
          state_s = S_IDLE;
        end
      end
      S_SETUP: begin
        state_s = S_PHI;
        cnt_s   = PHI_LD;
      end
      S_PHI: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_GAP1;
          cnt_s   = GAP_LD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_GAP1: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_PHIB;
          cnt_s   = PHI_LD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_PHIB: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_GAP2;
          cnt_s   = GAP_LD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_GAP2: begin
        if (cnt_r != CNT_ZERO) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else if (bit_r == len_r - LEN_W'(1)) begin
          state_s = S_DONE;
        end else begin
          state_s = S_SETUP;
          bit_s   = bit_r + LEN_W'(1);
        end
      end
      S_CAP_SET: begin
        state_s = S_CAP_PHIB;
        cnt_s   = PHI_LD;
      end
      S_CAP_PHIB: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_CAP_HOLD;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_CAP_HOLD: state_s = S_DONE;
      S_UPD: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = S_DONE;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // chain_si comes from the incoming word on the accept cycle, later from the latched copy.
  always_comb begin
    data_src_s   = accept_s ? cmd_data : data_r;
    data_shift_s = data_src_s >> bit_s;
    in_shift_s   = (state_s == S_SETUP) || (state_s == S_PHI) || (state_s == S_GAP1) ||
                   (state_s == S_PHIB)  || (state_s == S_GAP2);
  end

  // FSM state, counters and latched command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      cnt_r   <= CNT_ZERO;
      bit_r   <= LEN_ZERO;
      len_r   <= LEN_ZERO;
      op_r    <= 2'b11;
      data_r  <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      if (accept_s) begin
        len_r  <= len_clamp_s;
        op_r   <= cmd_op;
        data_r <= cmd_data;
      end
    end
  end

  // Chain tail sampling and response word, published only when a command completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_in_r <= {DATA_W{1'b0}};
      rsp_data_r <= {DATA_W{1'b0}};
    end else begin
      if (accept_s) begin
        shift_in_r <= {DATA_W{1'b0}};
      end else if (state_r == S_SETUP) begin
        shift_in_r <= shift_in_r | ({{(DATA_W-1){1'b0}}, chain_so} << bit_r);
      end
      if (state_r == S_DONE) begin
        rsp_data_r <= (op_r == OP_SHIFT) ? shift_in_r : {DATA_W{1'b0}};
      end
    end
  end

  // Registered strobes and handshake outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi_r       <= 1'b0;
      phi_bar_r   <= 1'b0;
      capture_r   <= 1'b0;
      update_r    <= 1'b0;
      chain_si_r  <= 1'b0;
      rsp_valid_r <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      phi_r       <= (state_s == S_PHI);
      phi_bar_r   <= (state_s == S_PHIB) || (state_s == S_CAP_PHIB);
      capture_r   <= (state_s == S_CAP_SET) || (state_s == S_CAP_PHIB) || (state_s == S_CAP_HOLD);
      update_r    <= (state_s == S_UPD);
      chain_si_r  <= in_shift_s & data_shift_s[0];
      rsp_valid_r <= (state_r == S_DONE);
      cmd_ready_r <= (state_s == S_IDLE);
      busy_r      <= (state_s != S_IDLE);
    end
  end

`ifdef SCAN_CHAIN_CTRL_OVERLAP_CHK_EN
  logic err_overlap_r;

  // Sticky flag for forbidden phase combinations seen on the registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overlap_r <= 1'b0;
    end else begin
      err_overlap_r <= err_overlap_r | (phi_r & phi_bar_r) | (phi_r & update_r);
    end
  end

  assign err_overlap = err_overlap_r;
`else
  assign err_overlap = 1'b0;
`endif

  assign phi       = phi_r;
  assign phi_bar   = phi_bar_r;
  assign capture   = capture_r;
  assign update    = update_r;
  assign chain_si  = chain_si_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: drives a 4-cell two-phase latch chain and checks against a
// word-level chain model (queue-style shift, capture load, update copy).
module tb_scan_chain_ctrl;

  localparam int DATA_W  = 32;
  localparam int PHI_W   = 2;
  localparam int GAP_W   = 1;
  localparam int UPD_W   = 2;
  localparam int LEN_W   = $clog2(DATA_W+1);
  localparam int BIT_CYC = 1 + 2*PHI_W + 2*GAP_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = 2'b11;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_data = '0;
  logic              cmd_ready, rsp_valid, busy, chain_si, chain_so;
  logic              phi, phi_bar, capture, update, err_overlap;
  logic [DATA_W-1:0] rsp_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.DATA_W(DATA_W), .PHI_W(PHI_W), .GAP_W(GAP_W), .UPD_W(UPD_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .chain_si(chain_si), .chain_so(chain_so),
    .phi(phi), .phi_bar(phi_bar), .capture(capture), .update(update),
    .err_overlap(err_overlap)
  );

  // Behavioural chain: cell0 is the head, cell3 the tail; chip words are cell3..0.
  logic [3:0] m_lat, s_lat, chip_out, chip_in;
  assign chain_so = s_lat[3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lat   <= 4'h0;
      s_lat   <= 4'h0;
      chip_in <= 4'h0;
    end else begin
      if (phi)     m_lat   <= {s_lat[2:0], chain_si};
      if (phi_bar) s_lat   <= capture ? chip_out : m_lat;
      if (update)  chip_in <= s_lat;
    end
  end

  // Cumulative strobe monitor, sampled on the falling edge.
  int   phi_cyc = 0, phi_pul = 0, phib_cyc = 0, phib_pul = 0;
  int   cap_cyc = 0, upd_cyc = 0, upd_pul = 0, viol = 0, gap_cnt = 0;
  logic phi_q = 1'b0, phib_q = 1'b0, upd_q = 1'b0, was_phi = 1'b0;
  logic si_log[$];
  logic sib_log[$];

  always @(negedge clk) begin
    if (phi && phi_bar) viol++;
    if (phi && update) viol++;
    if (phi && capture) viol++;
    if (phi_bar && !phib_q && was_phi && gap_cnt < GAP_W) viol++;
    if (phi) begin
      phi_cyc++;
      if (!phi_q) begin
        phi_pul++;
        si_log.push_back(chain_si);
      end
      gap_cnt = 0;
      was_phi = 1'b1;
    end else if (!phi_bar) begin
      gap_cnt++;
    end
    if (phi_bar) begin
      phib_cyc++;
      was_phi = 1'b0;
      if (!phib_q) begin
        phib_pul++;
        if (!capture) sib_log.push_back(chain_si);
      end
    end
    if (capture) cap_cyc++;
    if (update) begin
      upd_cyc++;
      if (!upd_q) upd_pul++;
    end
    phi_q  = phi;
    phib_q = phi_bar;
    upd_q  = update;
  end

  // Reference model state: cells in cell3..0 order.
  logic [3:0] mc = 4'h0;
  logic [3:0] exp_chip = 4'h0;

  // Per-command deltas of the monitor counters.
  int d_phi_cyc, d_phi_pul, d_phib_cyc, d_phib_pul, d_cap_cyc, d_upd_cyc, d_upd_pul;
  int si_base, sib_base;

  function automatic logic [3:0] so_word(input logic [3:0] c);
    logic [3:0] w;
    for (int i = 0; i < 4; i++) w[i] = c[3-i];
    return w;
  endfunction

  task automatic model_cmd(input logic [1:0] op, input int len, input logic [DATA_W-1:0] data,
                           output int e_lat, output logic [DATA_W-1:0] e_rsp, output int e_pul);
    int n;
    n     = (len > DATA_W) ? DATA_W : len;
    e_rsp = '0;
    e_pul = 0;
    case (op)
      2'b00: begin
        for (int i = 0; i < n; i++) begin
          e_rsp[i] = mc[3];
          mc = {mc[2:0], data[i]};
        end
        e_pul = n;
        e_lat = 1 + n*BIT_CYC + 1;
      end
      2'b01: begin
        mc    = chip_out;
        e_lat = PHI_W + 4;
      end
      2'b10: begin
        exp_chip = mc;
        e_lat    = UPD_W + 2;
      end
      default: e_lat = 2;
    endcase
  endtask

  task automatic do_cmd(input logic [1:0] op, input int len, input logic [DATA_W-1:0] data,
                        output int lat, output logic [DATA_W-1:0] rd);
    int w, b0, b1, b2, b3, b4, b5, b6;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait: cmd_ready=%0b required=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = LEN_W'(len);
    cmd_data  = data;
    @(posedge clk);
    b0 = phi_cyc; b1 = phi_pul; b2 = phib_cyc; b3 = phib_pul; b4 = cap_cyc; b5 = upd_cyc; b6 = upd_pul;
    si_base  = si_log.size();
    sib_base = sib_log.size();
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_data;
    d_phi_cyc = phi_cyc - b0; d_phi_pul = phi_pul - b1; d_phib_cyc = phib_cyc - b2;
    d_phib_pul = phib_pul - b3; d_cap_cyc = cap_cyc - b4; d_upd_cyc = upd_cyc - b5;
    d_upd_pul = upd_pul - b6;
  endtask

  task automatic test_reset;
    int w, seen;
    repeat (3) @(negedge clk);
    checks++;
    if ({phi, phi_bar, capture, update, chain_si, rsp_valid, busy} !== 7'b0)
      begin failures++; $display("FAIL reset_outputs: got=%b required=0000000", {phi, phi_bar, capture, update, chain_si, rsp_valid, busy}); end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_data !== '0)
      begin failures++; $display("FAIL reset_ready_data: cmd_ready=%0b rsp_data=%0h required 1/0", cmd_ready, rsp_data); end
    rst_n = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_len = LEN_W'(8); cmd_data = $urandom;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (!phi && w < 20) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (phi !== 1'b1) begin failures++; $display("FAIL reset_reach_phi: phi=%0b required=1", phi); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({phi, phi_bar, capture, update, chain_si} !== 5'b0)
      begin failures++; $display("FAIL reset_abort_strobes: got=%b required=00000", {phi, phi_bar, capture, update, chain_si}); end
    @(negedge clk);
    rst_n = 1'b1;
    mc = 4'h0;
    exp_chip = 4'h0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || busy !== 1'b0)
      begin failures++; $display("FAIL reset_release: ready=%0b rsp_valid=%0b busy=%0b required 1/0/0", cmd_ready, rsp_valid, busy); end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_no_rsp: rsp_valid cycles=%0d required=0", seen); end
  endtask

  task automatic test_shift;
    int lat, e_lat, e_pul;
    logic [DATA_W-1:0] rd, e_rsp, keep;
    model_cmd(2'b00, 4, 32'hB, e_lat, e_rsp, e_pul);
    do_cmd(2'b00, 4, 32'hB, lat, rd);
    checks++;
    if (lat != 30) begin failures++; $display("FAIL shift_latency: got=%0d required=30", lat); end
    checks++;
    if (rd !== 32'h0 || rd !== e_rsp) begin failures++; $display("FAIL shift_rsp: got=%0h required=%0h", rd, e_rsp); end
    checks++;
    if (d_phi_pul != 4 || d_phi_cyc != 8) begin failures++; $display("FAIL shift_phi: pulses=%0d cycles=%0d required 4/8", d_phi_pul, d_phi_cyc); end
    checks++;
    if (d_phib_pul != 4 || d_phib_cyc != 8) begin failures++; $display("FAIL shift_phib: pulses=%0d cycles=%0d required 4/8", d_phib_pul, d_phib_cyc); end
    checks++;
    if ({si_log[si_base+3], si_log[si_base+2], si_log[si_base+1], si_log[si_base]} !== 4'b1011 ||
        {sib_log[sib_base+3], sib_log[sib_base+2], sib_log[sib_base+1], sib_log[sib_base]} !== 4'b1011)
      begin failures++; $display("FAIL shift_chain_si: phi-order=%b%b%b%b required 1101 (bit0 first)", si_log[si_base], si_log[si_base+1], si_log[si_base+2], si_log[si_base+3]); end
    checks++;
    if (so_word(s_lat) !== 4'hB || s_lat !== mc) begin failures++; $display("FAIL shift_cells: got=%0h required=%0h", so_word(s_lat), 4'hB); end
    keep = rsp_data;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== keep) begin failures++; $display("FAIL shift_rsp_pulse: rsp_valid=%0b rsp_data=%0h required 0/%0h", rsp_valid, rsp_data, keep); end
  endtask

  task automatic test_capture;
    int lat, e_lat, e_pul;
    logic [DATA_W-1:0] rd, e_rsp;
    chip_out = 4'b1010;
    model_cmd(2'b01, 0, '0, e_lat, e_rsp, e_pul);
    do_cmd(2'b01, 0, '0, lat, rd);
    checks++;
    if (lat != 6) begin failures++; $display("FAIL capture_latency: got=%0d required=6", lat); end
    checks++;
    if (d_cap_cyc != 4 || d_phib_cyc != 2 || d_phi_cyc != 0)
      begin failures++; $display("FAIL capture_strobes: cap=%0d phib=%0d phi=%0d required 4/2/0", d_cap_cyc, d_phib_cyc, d_phi_cyc); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL capture_rsp: got=%0h required=0", rd); end
    model_cmd(2'b00, 4, '0, e_lat, e_rsp, e_pul);
    do_cmd(2'b00, 4, '0, lat, rd);
    checks++;
    if (rd !== 32'h5 || rd !== e_rsp) begin failures++; $display("FAIL capture_shift_out: got=%0h required=%0h", rd, e_rsp); end
  endtask

  task automatic test_update;
    int lat, e_lat, e_pul;
    logic [DATA_W-1:0] rd, e_rsp, d;
    d = DATA_W'($urandom_range(1, 15));
    model_cmd(2'b00, 4, d, e_lat, e_rsp, e_pul);
    do_cmd(2'b00, 4, d, lat, rd);
    model_cmd(2'b10, 0, '0, e_lat, e_rsp, e_pul);
    do_cmd(2'b10, 0, '0, lat, rd);
    checks++;
    if (lat != 4) begin failures++; $display("FAIL update_latency: got=%0d required=4", lat); end
    checks++;
    if (d_upd_cyc != 2 || d_upd_pul != 1) begin failures++; $display("FAIL update_width: cycles=%0d pulses=%0d required 2/1", d_upd_cyc, d_upd_pul); end
    checks++;
    if (d_phi_cyc != 0 || d_phib_cyc != 0) begin failures++; $display("FAIL update_phases: phi=%0d phib=%0d required 0/0", d_phi_cyc, d_phib_cyc); end
    checks++;
    if (so_word(chip_in) !== d[3:0] || chip_in !== exp_chip) begin failures++; $display("FAIL update_chip_in: got=%0h required=%0h", so_word(chip_in), d[3:0]); end
  endtask

  task automatic test_edge_lengths;
    int lat, e_lat, e_pul;
    logic [DATA_W-1:0] rd, e_rsp, d;
    d = $urandom;
    model_cmd(2'b00, 0, d, e_lat, e_rsp, e_pul);
    do_cmd(2'b00, 0, d, lat, rd);
    checks++;
    if (lat != 2 || d_phi_pul != 0 || d_phib_pul != 0) begin failures++; $display("FAIL len0: latency=%0d pulses=%0d required 2/0", lat, d_phi_pul); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL len0_rsp: got=%0h required=0", rd); end
    d = $urandom;
    model_cmd(2'b00, 40, d, e_lat, e_rsp, e_pul);
    do_cmd(2'b00, 40, d, lat, rd);
    checks++;
    if (lat != 2 + 32*BIT_CYC) begin failures++; $display("FAIL len40_latency: got=%0d required=%0d", lat, 2 + 32*BIT_CYC); end
    checks++;
    if (d_phi_pul != 32 || d_phib_pul != 32) begin failures++; $display("FAIL len40_pulses: phi=%0d phib=%0d required 32/32", d_phi_pul, d_phib_pul); end
    checks++;
    if (rd !== e_rsp) begin failures++; $display("FAIL len40_rsp: got=%0h required=%0h", rd, e_rsp); end
  endtask

  task automatic test_back_to_back;
    int lat, lat2, w, e_lat, e_pul, b_upd;
    logic [DATA_W-1:0] e_rsp;
    model_cmd(2'b10, 0, '0, e_lat, e_rsp, e_pul);
    model_cmd(2'b11, 0, '0, e_lat, e_rsp, e_pul);
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    @(posedge clk);
    b_upd = upd_cyc;
    @(negedge clk);
    cmd_op = 2'b11;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != 4 || cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_first: latency=%0d ready=%0b required 4/1", lat, cmd_ready); end
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: rsp_valid=%0b busy=%0b required 0/1", rsp_valid, busy); end
    lat2 = 1;
    while (!rsp_valid && lat2 < 50) begin
      @(negedge clk);
      lat2++;
    end
    checks++;
    if (lat2 != 2 || rsp_data !== 32'h0) begin failures++; $display("FAIL b2b_second: latency=%0d rsp_data=%0h required 2/0", lat2, rsp_data); end
    checks++;
    if (upd_cyc - b_upd != 2 || chip_in !== exp_chip) begin failures++; $display("FAIL b2b_update: cycles=%0d chip_in=%0h required 2/%0h", upd_cyc - b_upd, chip_in, exp_chip); end
  endtask

  task automatic test_random;
    int lat, e_lat, e_pul, len;
    logic [1:0] op;
    logic [DATA_W-1:0] rd, e_rsp, d;
    for (int k = 0; k < 20; k++) begin
      op  = 2'($urandom_range(0, 3));
      len = $urandom_range(0, 40);
      d   = $urandom;
      if (op == 2'b01) chip_out = 4'($urandom);
      model_cmd(op, len, d, e_lat, e_rsp, e_pul);
      do_cmd(op, len, d, lat, rd);
      checks++;
      if (lat != e_lat || rd !== e_rsp || d_phi_pul != e_pul)
        begin failures++; $display("FAIL random_cmd%0d op=%0d len=%0d: latency=%0d rsp=%0h pulses=%0d required %0d/%0h/%0d", k, op, len, lat, rd, d_phi_pul, e_lat, e_rsp, e_pul); end
      if (op == 2'b10) begin
        checks++;
        if (chip_in !== exp_chip) begin failures++; $display("FAIL random_update%0d: chip_in=%0h required=%0h", k, chip_in, exp_chip); end
      end
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (viol != 0) begin failures++; $display("FAIL phase_invariants: violations=%0d required=0", viol); end
    checks++;
    if (err_overlap !== 1'b0) begin failures++; $display("FAIL err_overlap: got=%0b required=0", err_overlap); end
  endtask

  initial begin
    chip_out = 4'h0;
    test_reset();
    test_shift();
    test_capture();
    test_update();
    test_edge_lengths();
    test_back_to_back();
    test_random();
    test_invariants();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
